// File: rtl/wb_spi_pkg.sv
// Shared types for the Wishbone SPI master: FSM state encoding, latched
// per-transfer mode bits and a width helper for index-sized ports.
package wb_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_ACT   = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
    logic auto_cs;
  } spi_mode_t;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_presc.sv
// Half-period prescaler: reloadable down-counter, tick in the cycle it reads zero while enabled.
// Tick is combinational from the count register; no backpressure.
module spi_presc #(
  parameter int PRESCW = 4
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic              load,
  input  logic              en,
  input  logic [PRESCW-1:0] presc,
  output logic              tick
);

  logic [PRESCW-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      cnt <= '0;
    end else if (load || tick) begin
      cnt <= presc;
    end else if (en) begin
      cnt <= cnt - PRESCW'(1);
    end
  end

endmodule

// File: rtl/wb_spi_mcs.sv
// Wishbone SPI master, multi-CS: a write in IDLE starts a (2*nbits+2)*H-cycle transfer;
// writes while busy are held off with ack low, reads ack at once from the completion register.
module wb_spi_mcs
  import wb_spi_pkg::*;
#(
  parameter int  DATW   = 32,
  parameter int  PRESCW = 4,
  parameter int  NCS    = 2,
  localparam int CSW    = clog2_min1(NCS),
  localparam int SZW    = clog2_min1(DATW / 8)
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic              wb_spi_cyc_i,
  input  logic              wb_spi_stb_i,
  input  logic              wb_spi_we_i,
  output logic              wb_spi_ack_o,
  input  logic [DATW-1:0]   wb_spi_dat_i,
  output logic [DATW-1:0]   wb_spi_dat_o,
  input  logic [PRESCW-1:0] presc_i,
  input  logic [SZW-1:0]    size_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic              auto_cs_i,
  input  logic [CSW-1:0]    cs_sel_i,
  output logic              rdy_o,
  output logic              done_o,
  output logic [NCS-1:0]    spi_cs_o,
  output logic              spi_sck_o,
  output logic              spi_sdo_o,
  input  logic              spi_sdi_i
);

  localparam int IW  = clog2_min1(DATW);
  localparam int ECW = $clog2(2 * DATW) + 1;

  spi_state_e        state;
  spi_mode_t         mode;
  logic [PRESCW-1:0] presc_q;
  logic [SZW-1:0]    size_q;
  logic [CSW-1:0]    cs_sel_q;
  logic [DATW-1:0]   tx_q;
  logic [DATW-1:0]   rx_q;
  logic [DATW-1:0]   dat_q;
  logic [IW-1:0]     idx;
  logic [ECW-1:0]    edge_cnt;
  logic [ECW-1:0]    last_edge;
  logic              phase_q;
  logic              done_q;
  logic              idle;
  logic              accept;
  logic              tick;
  logic              odd_edge;
  logic              sample;
  logic              advance;

  assign idle         = (state == ST_IDLE);
  assign accept       = idle && wb_spi_cyc_i && wb_spi_stb_i && wb_spi_we_i;
  assign wb_spi_ack_o = rst_in && wb_spi_cyc_i && wb_spi_stb_i && (!wb_spi_we_i || idle);

  spi_presc #(
    .PRESCW(PRESCW)
  ) u_presc (
    .clk_i (clk_i),
    .rst_in(rst_in),
    .load  (accept),
    .en    (!idle),
    .presc (accept ? presc_i : presc_q),
    .tick  (tick)
  );

  // edge_cnt is the 0-based count of SCK edges already issued, so the edge
  // about to happen is odd when edge_cnt is even.
  assign last_edge = ECW'(16 * (int'(size_q) + 1) - 1);
  assign odd_edge  = !edge_cnt[0];
  assign sample    = mode.cpha ? !odd_edge : odd_edge;
  // The final CPHA=0 advance is dropped so the index never leaves the word.
  assign advance   = mode.cpha ? (odd_edge && (edge_cnt != '0))
                               : (!odd_edge && (edge_cnt != last_edge));

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state    <= ST_IDLE;
      mode     <= '0;
      presc_q  <= '0;
      size_q   <= '0;
      cs_sel_q <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      dat_q    <= '0;
      idx      <= '0;
      edge_cnt <= '0;
      phase_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mode     <= '{cpol: cpol_i, cpha: cpha_i, lsb_first: lsb_first_i, auto_cs: auto_cs_i};
            presc_q  <= presc_i;
            size_q   <= size_i;
            cs_sel_q <= cs_sel_i;
            tx_q     <= wb_spi_dat_i;
            rx_q     <= '0;
            idx      <= lsb_first_i ? '0 : IW'(8 * (int'(size_i) + 1) - 1);
            edge_cnt <= '0;
            phase_q  <= 1'b0;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) state <= ST_ACT;
        end
        ST_ACT: begin
          if (tick) begin
            phase_q  <= !phase_q;
            edge_cnt <= edge_cnt + ECW'(1);
            if (sample) rx_q[idx] <= spi_sdi_i;
            if (advance) idx <= mode.lsb_first ? idx + IW'(1) : idx - IW'(1);
            if (edge_cnt == last_edge) state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            dat_q  <= rx_q;
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    spi_cs_o = '1;
    if (!idle && mode.auto_cs) begin
      for (int i = 0; i < NCS; i++) begin
        if (int'(cs_sel_q) == i) spi_cs_o[i] = 1'b0;
      end
    end
  end

  assign spi_sck_o    = idle ? cpol_i : (mode.cpol ^ phase_q);
  assign spi_sdo_o    = idle ? 1'b0 : tx_q[idx];
  assign rdy_o        = idle;
  assign done_o       = done_q;
  assign wb_spi_dat_o = dat_q;

endmodule

// File: tb/tb_wb_spi_mcs.sv
// Directed bench for wb_spi_mcs with SDO looped back to SDI.
module tb_wb_spi_mcs;

  logic        clk_i = 1'b0;
  logic        rst_in;
  logic        cyc, stb, we;
  logic        ack;
  logic [31:0] dat_in, dat_out;
  logic [3:0]  presc;
  logic [1:0]  size;
  logic        cpol, cpha, lsb_first, auto_cs;
  logic [0:0]  cs_sel;
  logic        rdy, done;
  logic [1:0]  cs;
  logic        sck, sdo;

  int checks = 0;
  int errors = 0;

  int sck_rise = 0;
  int busy_cyc = 0;
  int done_cnt = 0;
  int cs_low0  = 0;
  int cs_low1  = 0;
  time t_last = 0;
  time t_prev = 0;

  always #5 clk_i = ~clk_i;

  wb_spi_mcs #(.DATW(32), .PRESCW(4), .NCS(2)) dut (
    .clk_i       (clk_i),
    .rst_in      (rst_in),
    .wb_spi_cyc_i(cyc),
    .wb_spi_stb_i(stb),
    .wb_spi_we_i (we),
    .wb_spi_ack_o(ack),
    .wb_spi_dat_i(dat_in),
    .wb_spi_dat_o(dat_out),
    .presc_i     (presc),
    .size_i      (size),
    .cpol_i      (cpol),
    .cpha_i      (cpha),
    .lsb_first_i (lsb_first),
    .auto_cs_i   (auto_cs),
    .cs_sel_i    (cs_sel),
    .rdy_o       (rdy),
    .done_o      (done),
    .spi_cs_o    (cs),
    .spi_sck_o   (sck),
    .spi_sdo_o   (sdo),
    .spi_sdi_i   (sdo)
  );

  always @(posedge sck) sck_rise++;
  always @(sck) begin
    t_prev = t_last;
    t_last = $time;
  end
  always @(negedge clk_i) begin
    if (!rdy) busy_cyc++;
    if (done) done_cnt++;
    if (!cs[0]) cs_low0++;
    if (!cs[1]) cs_low1++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] d, output int wcyc);
    @(posedge clk_i); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; dat_in = d; wcyc = 0;
    while (1) begin
      @(negedge clk_i);
      if (ack) break;
      wcyc++;
      if (wcyc > 2000) begin
        wcyc = -1;
        break;
      end
    end
    @(posedge clk_i); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(output logic [31:0] d, output logic a);
    @(posedge clk_i); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    @(negedge clk_i);
    d = dat_out;
    a = ack;
    @(posedge clk_i); #1;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < budget) begin
      @(negedge clk_i);
      if (done) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
  endtask

  initial begin
    int          wcyc, b_busy, b_rise, b_done, b_cs0, b_cs1;
    logic        ok, a;
    logic [31:0] rd, prev, first;

    rst_in = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; dat_in = '0;
    presc = 4'd0; size = 2'd0; cpol = 1'b0; cpha = 1'b0;
    lsb_first = 1'b0; auto_cs = 1'b1; cs_sel = 1'b0;

    // Reset values, with a read strobe held to show ack is gated.
    #3;
    chk("rst_ack", ack, 0);
    chk("rst_rdy", rdy, 1);
    chk("rst_done", done, 0);
    chk("rst_cs", cs, 2'b11);
    chk("rst_sck", sck, 0);
    chk("rst_sdo", sdo, 0);
    chk("rst_dat", dat_out, 0);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_in = 1'b1;

    // Mode 0, presc 0, one byte, CS0.
    b_busy = busy_cyc; b_rise = sck_rise; b_done = done_cnt; b_cs0 = cs_low0; b_cs1 = cs_low1;
    wb_write(32'h0000_00A5, wcyc);
    chk("t1_wr_wait", wcyc, 0);
    @(negedge clk_i);
    chk("t1_sdo_first", sdo, 1);
    wait_done(100, ok);
    chk("t1_done_seen", ok, 1);
    chk("t1_rdy_with_done", rdy, 1);
    @(negedge clk_i);
    chk("t1_done_pulse", done, 0);
    chk("t1_busy", busy_cyc - b_busy, 18);
    chk("t1_sck_rise", sck_rise - b_rise, 8);
    chk("t1_done_cnt", done_cnt - b_done, 1);
    chk("t1_cs0_low", cs_low0 - b_cs0, 18);
    chk("t1_cs1_low", cs_low1 - b_cs1, 0);
    wb_read(rd, a);
    chk("t1_rd_ack", a, 1);
    chk("t1_rd_dat", rd, 32'h0000_00A5);

    // Mode 3, LSB first, 4 bytes, CS1; inputs change right after accept.
    cpol = 1'b1; cpha = 1'b1; lsb_first = 1'b1; size = 2'd3; cs_sel = 1'b1;
    b_busy = busy_cyc; b_cs0 = cs_low0; b_cs1 = cs_low1;
    wb_write(32'h1234_5678, wcyc);
    chk("t2_wr_wait", wcyc, 0);
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; size = 2'd0; cs_sel = 1'b0;
    @(negedge clk_i);
    chk("t2_sdo_first", sdo, 0);
    chk("t2_sck_latched", sck, 1);
    repeat (10) @(negedge clk_i);
    chk("t2_sdo_bit4", sdo, 1);
    wait_done(200, ok);
    chk("t2_done_seen", ok, 1);
    @(negedge clk_i);
    chk("t2_busy", busy_cyc - b_busy, 66);
    chk("t2_cs0_low", cs_low0 - b_cs0, 0);
    chk("t2_cs1_low", cs_low1 - b_cs1, 66);
    wb_read(rd, a);
    chk("t2_rd_dat", rd, 32'h1234_5678);

    // Back-to-back writes: second one waits out the first transfer.
    size = 2'd1;
    b_done = done_cnt;
    wb_write(32'h0000_BEEF, wcyc);
    chk("t3_wr1_wait", wcyc, 0);
    wb_write(32'h0000_1234, wcyc);
    chk("t3_wr2_wait", wcyc, 33);
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    @(negedge clk_i);
    first = dat_out;
    prev  = first;
    rd    = first;
    ok    = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_i);
      prev = rd;
      rd   = dat_out;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    a = ack;
    cyc = 1'b0; stb = 1'b0;
    chk("t3_done_seen", ok, 1);
    chk("t3_rd_during", first, 32'h0000_BEEF);
    chk("t3_rd_before_done", prev, 32'h0000_BEEF);
    chk("t3_rd_at_done", rd, 32'h0000_1234);
    chk("t3_rd_ack", a, 1);
    @(negedge clk_i);
    chk("t3_done_cnt", done_cnt - b_done, 2);

    // presc 3, no automatic CS.
    presc = 4'd3; auto_cs = 1'b0; size = 2'd0;
    b_busy = busy_cyc; b_cs0 = cs_low0; b_cs1 = cs_low1;
    wb_write(32'h0000_003C, wcyc);
    chk("t4_wr_wait", wcyc, 0);
    wait_done(300, ok);
    chk("t4_done_seen", ok, 1);
    @(negedge clk_i);
    chk("t4_busy", busy_cyc - b_busy, 72);
    chk("t4_half_period", t_last - t_prev, 40);
    chk("t4_cs0_low", cs_low0 - b_cs0, 0);
    chk("t4_cs1_low", cs_low1 - b_cs1, 0);
    wb_read(rd, a);
    chk("t4_rd_dat", rd, 32'h0000_003C);

    // Reset in the middle of ACT.
    auto_cs = 1'b1; cpol = 1'b1; cs_sel = 1'b0;
    wb_write(32'h0000_00FF, wcyc);
    chk("t5_wr_wait", wcyc, 0);
    repeat (10) @(negedge clk_i);
    chk("t5_cs_active", cs, 2'b10);
    b_done = done_cnt;
    #2;
    rst_in = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    #1;
    chk("t5_cs_rst", cs, 2'b11);
    chk("t5_sck_rst", sck, 1);
    chk("t5_sdo_rst", sdo, 0);
    chk("t5_dat_rst", dat_out, 0);
    chk("t5_rdy_rst", rdy, 1);
    chk("t5_ack_rst", ack, 0);
    cpol = 1'b0;
    #1;
    chk("t5_sck_live", sck, 0);
    cyc = 1'b0; stb = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_in = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("t5_no_done", done_cnt - b_done, 0);
    wb_read(rd, a);
    chk("t5_rd_dat", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
